// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency/period meter.
// Default gate is one second of the 50 MHz system clock, so freq reads in Hz.
package freq_meter_pkg;

    localparam int CLK_HZ          = 50_000_000;
    localparam int DEF_GATE_CYCLES = CLK_HZ;
    localparam int DEF_CNT_W       = 20;
    localparam int DEF_PER_W       = 27;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchroniser for an asynchronous input with rising-edge detect.
// Ports: clk, rst (async, active-high), sig (async in), rise (1-cycle pulse).
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    // s[0] is the metastability catcher; edges are judged on s[1] vs s[2].
    logic [2:0] s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= {s[1:0], sig};
        end
    end

    assign rise = s[1] & ~s[2];

endmodule

// File: rtl/freq_meter.sv
// Frequency (edges per gate window) and period (cycles between edges) meter.
// Ports: clk_50m, rst, en, sig_in; freq/freq_vld/freq_ovf, period/period_vld, no_signal.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PER_W       = DEF_PER_W
) (
    input  logic             clk_50m,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_vld,
    output logic             freq_ovf,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             no_signal
);

    localparam int             GW        = cnt_width(GATE_CYCLES);
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);

    logic             rise;
    logic [GW-1:0]    gate_cnt;
    logic             gate_end;
    logic [CNT_W-1:0] edge_cnt;
    logic             sat;
    logic [CNT_W:0]   sum;
    logic [PER_W-1:0] per_cnt;
    logic             per_max;
    logic             seen_edge;

    edge_sync u_sync (
        .clk  (clk_50m),
        .rst  (rst),
        .sig  (sig_in),
        .rise (rise)
    );

    assign gate_end = en & (gate_cnt == GATE_LAST);

    // An edge landing on the closing cycle still belongs to that window,
    // so it is folded into the result rather than the fresh count.
    assign sum     = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, rise};
    assign per_max = &per_cnt;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            freq     <= '0;
            freq_ovf <= 1'b0;
            freq_vld <= 1'b0;
        end else begin
            freq_vld <= 1'b0;
            if (!en) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (gate_end) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
                freq     <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                freq_ovf <= sat | sum[CNT_W];
                freq_vld <= 1'b1;
            end else begin
                gate_cnt <= gate_cnt + GW'(1);
                if (rise) begin
                    if (&edge_cnt) begin
                        sat <= 1'b1;
                    end else begin
                        edge_cnt <= edge_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Period path ignores en so a pickup is timed even between gates.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            per_cnt    <= '0;
            seen_edge  <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            if (rise) begin
                if (seen_edge) begin
                    period     <= per_max ? per_cnt : per_cnt + PER_W'(1);
                    period_vld <= 1'b1;
                end
                per_cnt   <= '0;
                seen_edge <= 1'b1;
                no_signal <= 1'b0;
            end else if (per_max) begin
                // Stalled input: forget the last edge so the next one
                // restarts timing instead of reporting a bogus period.
                no_signal <= 1'b1;
                seen_edge <= 1'b0;
            end else begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end

endmodule
